// File: rtl/xorshift32_arbiter.sv
// xorshift32_arbiter
// Round-robin scheduler sharing one Xorshift32 generator among N_REQ
// requesters. Each grant hands one fresh 32-bit word to exactly one requester.
// After reset or reseed, WARMUP generator advances are discarded before any
// request is served.
//
// Build option: define XORSHIFT32_ARB_ZERO_GUARD_EN to replace a loaded seed
// of zero with 32'h2545F491. Without it, a zero seed is loaded as-is and the
// generator then produces zero forever.
//
// FSM states:
//   S_WARMUP | discarding advances, busy=1, requests ignored
//   S_RUN    | arbitrating, one grant per cycle at most
module xorshift32_arbiter #(
  parameter int          N_REQ        = 4,
  parameter logic [31:0] DEFAULT_SEED = 32'h12345678,
  parameter int          WARMUP       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             rnd_valid,
  output logic [31:0]      rnd,
  output logic             busy
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [7:0]    WCNT_INIT = 8'(WARMUP);
  localparam logic [PW-1:0] PTR_INIT  = PW'(N_REQ - 1);

  typedef enum logic {S_WARMUP, S_RUN} state_t;

  // A zero warm-up length means the block comes out of reset/reseed ready.
  localparam state_t STATE_INIT = (WARMUP == 0) ? S_RUN : S_WARMUP;

  state_t           fsm;
  logic [7:0]       wcnt;
  logic [31:0]      state_q;
  logic [PW-1:0]    ptr;

  logic [31:0]      seed_eff;
  logic [31:0]      xs_next;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] onehot;
  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    scan_idx;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

`ifdef XORSHIFT32_ARB_ZERO_GUARD_EN
  assign seed_eff = (seed == 32'h0) ? 32'h2545F491 : seed;
`else
  assign seed_eff = seed;
`endif

  assign xs_next = xs(state_q);
  assign busy    = (fsm == S_WARMUP);

  // Round-robin pick: first eligible requester after ptr, wrapping; the
  // current holder is masked so nobody wins two cycles in a row.
  always_comb begin
    eligible  = req & ~grant;
    win_found = 1'b0;
    win_idx   = ptr;
    scan_idx  = ptr;
    onehot    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_idx = PW'((int'(ptr) + i) % N_REQ);
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
    onehot[win_idx] = 1'b1;
  end

  // Sequencer: reseed has priority over everything, then warm-up, then arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= STATE_INIT;
      wcnt      <= WCNT_INIT;
      state_q   <= DEFAULT_SEED;
      ptr       <= PTR_INIT;
      grant     <= '0;
      rnd_valid <= 1'b0;
      rnd       <= '0;
    end else if (seed_load) begin
      fsm       <= STATE_INIT;
      wcnt      <= WCNT_INIT;
      state_q   <= seed_eff;
      grant     <= '0;
      rnd_valid <= 1'b0;
    end else begin
      case (fsm)
        S_WARMUP: begin
          state_q   <= xs_next;
          wcnt      <= wcnt - 8'd1;
          grant     <= '0;
          rnd_valid <= 1'b0;
          if (wcnt == 8'd1) fsm <= S_RUN;
        end
        S_RUN: begin
          if (win_found) begin
            grant     <= onehot;
            rnd_valid <= 1'b1;
            rnd       <= xs_next;
            state_q   <= xs_next;
            ptr       <= win_idx;
          end else begin
            grant     <= '0;
            rnd_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xorshift32_arbiter.sv
// Bench for xorshift32_arbiter: a WARMUP=8 instance driven with random
// requests/reseeds and checked through a scoreboard fed by a high-level
// model, plus a WARMUP=0 instance exercised with directed vectors.
`timescale 1ns/1ps
module tb_xorshift32_arbiter;

  localparam int          N     = 4;
  localparam int          WU    = 8;
  localparam logic [31:0] DSEED = 32'h12345678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst, seed_load;
  logic [31:0]   seed, rnd;
  logic [N-1:0]  req, grant;
  logic          rnd_valid, busy;

  // zero-warm-up instance
  logic          rst0, sl0;
  logic [31:0]   seed0, rnd0;
  logic [N-1:0]  req0, grant0;
  logic          v0, busy0;

  xorshift32_arbiter #(.N_REQ(N), .DEFAULT_SEED(DSEED), .WARMUP(WU)) u_dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .grant(grant), .rnd_valid(rnd_valid), .rnd(rnd), .busy(busy));

  xorshift32_arbiter #(.N_REQ(N), .DEFAULT_SEED(DSEED), .WARMUP(0)) u_dut0 (
    .clk(clk), .rst(rst0), .seed_load(sl0), .seed(seed0), .req(req0),
    .grant(grant0), .rnd_valid(v0), .rnd(rnd0), .busy(busy0));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] guard(input logic [31:0] s);
`ifdef XORSHIFT32_ARB_ZERO_GUARD_EN
    return (s == 32'h0) ? 32'h2545F491 : s;
`else
    return s;
`endif
  endfunction

  // reference model state and scoreboard
  typedef struct {
    int          edge_no;
    int          who;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_x;
  int          m_wcnt, m_ptr, m_last;

  task automatic model_reset();
    m_x    = DSEED;
    m_wcnt = WU;
    m_ptr  = N - 1;
    m_last = -1;
    q.delete();
  endtask

  // monitor
  int          edge_n   = 0;
  logic        mon_en   = 1'b0;
  logic [31:0] hold_rnd = 32'h0;
  int          rec_sel  = 0;
  logic [31:0] rec_a[$];
  logic [31:0] rec_b[$];
  exp_t        e;

  always @(posedge clk) begin
    #1;
    edge_n++;
    if (mon_en) begin
      if (rnd_valid) begin
        if (q.size() == 0) begin
          check("grant_expected", 32'(q.size()), 32'd1);
        end else begin
          e = q.pop_front();
          check("grant_edge", 32'(edge_n), 32'(e.edge_no));
          check("grant_who", 32'(grant), 32'd1 << e.who);
          check("grant_rnd", rnd, e.val);
          hold_rnd = e.val;
          if (rec_sel == 1) rec_a.push_back(rnd);
          if (rec_sel == 2) rec_b.push_back(rnd);
        end
      end else begin
        check("idle_grant", 32'(grant), 32'd0);
        check("rnd_hold", rnd, hold_rnd);
      end
    end
  end

  // drive one cycle of the main DUT and advance the model to the next edge
  task automatic step(input logic [N-1:0] r, input logic sl, input logic [31:0] s);
    int w;
    @(negedge clk);
    check("busy", 32'(busy), 32'(m_wcnt > 0));
    req       = r;
    seed_load = sl;
    seed      = s;
    if (sl) begin
      m_x    = guard(s);
      m_wcnt = WU;
      m_last = -1;
    end else if (m_wcnt > 0) begin
      m_x    = xs(m_x);
      m_wcnt = m_wcnt - 1;
      m_last = -1;
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && r[c] && c != m_last) w = c;
      end
      if (w >= 0) begin
        m_x = xs(m_x);
        q.push_back('{edge_n + 1, w, m_x});
        m_ptr = w;
      end
      m_last = w;
    end
  endtask

  // asynchronous reset in the middle of a cycle
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_valid"}, 32'(rnd_valid), 32'd0);
    check({tag, "_rnd"}, rnd, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    model_reset();
    hold_rnd = 32'h0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic u0_cycle(input logic [N-1:0] r, input logic sl, input logic [31:0] s);
    @(negedge clk);
    req0  = r;
    sl0   = sl;
    seed0 = s;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] x0;

  initial begin
    rst = 1'b1; seed_load = 1'b0; seed = '0; req = '0;
    rst0 = 1'b1; sl0 = 1'b0; seed0 = '0; req0 = '0;
    model_reset();
    #12;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_valid", 32'(rnd_valid), 32'd0);
    check("rst_rnd", rnd, 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst0_busy", 32'(busy0), 32'd0);

    // zero warm-up instance: all four requesting, seed=1
    @(posedge clk);
    #2;
    rst0 = 1'b0;
    u0_cycle(4'b1111, 1'b1, 32'd1);
    check("u0_load_valid", 32'(v0), 32'd0);
    x0 = 32'd1;
    for (int k = 0; k < 5; k++) begin
      u0_cycle(4'b1111, 1'b0, 32'd0);
      x0 = xs(x0);
      check("u0_rr_valid", 32'(v0), 32'd1);
      check("u0_rr_grant", 32'(grant0), 32'd1 << (k % N));
      check("u0_rr_rnd", rnd0, x0);
      if (k == 0) check("u0_vec0", rnd0, 32'h00042021);
      if (k == 1) check("u0_vec1", rnd0, 32'h04080601);
    end

    // single requester held: served on alternate cycles
    u0_cycle(4'b0001, 1'b1, 32'd1);
    check("u0_sl_wins", 32'(v0), 32'd0);
    u0_cycle(4'b0001, 1'b0, 32'd0);
    check("u0_single_v1", 32'(v0), 32'd1);
    check("u0_single_r1", rnd0, 32'h00042021);
    u0_cycle(4'b0001, 1'b0, 32'd0);
    check("u0_single_gap", 32'(v0), 32'd0);
    check("u0_single_hold", rnd0, 32'h00042021);
    u0_cycle(4'b0001, 1'b0, 32'd0);
    check("u0_single_v2", 32'(v0), 32'd1);
    check("u0_single_r2", rnd0, 32'h04080601);

    // zero seed
    u0_cycle(4'b0010, 1'b1, 32'd0);
    u0_cycle(4'b0010, 1'b0, 32'd0);
    x0 = xs(guard(32'd0));
    check("u0_zero_v", 32'(v0), 32'd1);
    check("u0_zero_rnd", rnd0, x0);
    u0_cycle(4'b0010, 1'b0, 32'd0);
    u0_cycle(4'b0010, 1'b0, 32'd0);
    check("u0_zero_rnd2", rnd0, xs(x0));
    u0_cycle(4'b0000, 1'b0, 32'd0);

    // main instance: release reset, warm-up with no requests
    @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) step(4'b0000, 1'b0, 32'd0);

    // random traffic with occasional reseeds (some with seed 0)
    for (int k = 0; k < 400; k++) begin
      logic sl;
      logic [31:0] s;
      sl = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step(N'($urandom_range(0, 15)), sl, s);
    end

    // reseed while a request is pending
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b0, 32'd0);
    step(4'b0100, 1'b1, 32'hCAFEF00D);
    for (int k = 0; k < 12; k++) step(4'b0110, 1'b0, 32'd0);

    // reset during warm-up
    step(4'b1111, 1'b1, $urandom);
    for (int k = 0; k < 3; k++) step(4'b1111, 1'b0, 32'd0);
    async_reset("rst_warm");

    // identical stream after two resets, second one hitting a live grant
    rec_sel = 1;
    for (int k = 0; k < 20; k++) step(4'b1011, 1'b0, 32'd0);
    async_reset("rst_grant");
    rec_sel = 2;
    for (int k = 0; k < 20; k++) step(4'b1011, 1'b0, 32'd0);
    async_reset("rst_end");
    rec_sel = 0;
    check("stream_len", 32'(rec_b.size()), 32'(rec_a.size()));
    for (int k = 0; k < rec_a.size() && k < rec_b.size(); k++)
      check("stream_word", rec_b[k], rec_a[k]);

    for (int k = 0; k < 12; k++) step(4'b0000, 1'b0, 32'd0);
    check("sb_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
